wb_bus_arbiter: RTL and testbench

Two-to-one Wishbone B4 (classic, non-pipelined) arbiter downstream of the core. It merges the core's instruction-fetch master port and data master port onto a single memory-side master port. The grant is registered and locked for the whole `cyc` cycle, with round-robin on contention. A bus-timeout watchdog terminates hung transfers with an error.

---
 rtl/wb_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-to-one Wishbone B4 classic arbiter: instruction and data masters share one memory port.
// The grant is locked for a whole cyc, round-robin on contention, with a watchdog abort.
module wb_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        iwbs_cyc_i,
   input  logic        iwbs_stb_i,
   input  logic [31:0] iwbs_addr_i,
   output logic [31:0] iwbs_dat_o,
   output logic        iwbs_ack_o,
   output logic        iwbs_err_o,
   input  logic        dwbs_cyc_i,
   input  logic        dwbs_stb_i,
   input  logic        dwbs_we_i,
   input  logic [3:0]  dwbs_sel_i,
   input  logic [31:0] dwbs_addr_i,
   input  logic [31:0] dwbs_dat_i,
   output logic [31:0] dwbs_dat_o,
   output logic        dwbs_ack_o,
   output logic        dwbs_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        timeout_o
);

   localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
   localparam int unsigned CNT_W    = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned LAST_VAL = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_VAL);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

   state_t           state;
   logic             last_d;
   logic [CNT_W-1:0] cnt;
   logic             timeout_q;

   logic req_i, req_d, gnt_i, gnt_d, own_cyc, resp, hung;

   assign req_i   = iwbs_cyc_i & iwbs_stb_i;
   assign req_d   = dwbs_cyc_i & dwbs_stb_i;
   assign gnt_i   = (state == GNT_I);
   assign gnt_d   = (state == GNT_D);
   assign own_cyc = gnt_d ? dwbs_cyc_i : iwbs_cyc_i;
   assign resp    = wbm_ack_i | wbm_err_i;
   assign hung    = WDOG_EN && wbm_stb_o && !resp && (cnt == CNT_LAST);

   // Memory-side request is a straight mux of the owner; IDLE and ABORT present an idle bus.
   assign wbm_cyc_o = (gnt_i & iwbs_cyc_i) | (gnt_d & dwbs_cyc_i);
   assign wbm_stb_o = (gnt_i & iwbs_cyc_i & iwbs_stb_i) | (gnt_d & dwbs_cyc_i & dwbs_stb_i);
   assign wbm_we_o  = gnt_d & dwbs_we_i;

   always_comb begin
      wbm_sel_o  = '0;
      wbm_addr_o = '0;
      wbm_dat_o  = '0;
      case (state)
         GNT_I: begin
            wbm_sel_o  = 4'hF;
            wbm_addr_o = iwbs_addr_i;
         end
         GNT_D: begin
            wbm_sel_o  = dwbs_sel_i;
            wbm_addr_o = dwbs_addr_i;
            wbm_dat_o  = dwbs_dat_i;
         end
         default: ;
      endcase
   end

   assign iwbs_dat_o = wbm_dat_i;
   assign dwbs_dat_o = wbm_dat_i;
   assign iwbs_ack_o = gnt_i & wbm_ack_i;
   assign dwbs_ack_o = gnt_d & wbm_ack_i;
   assign iwbs_err_o = (gnt_i & wbm_err_i) | (timeout_q & ~last_d);
   assign dwbs_err_o = (gnt_d & wbm_err_i) | (timeout_q & last_d);
   assign timeout_o  = timeout_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (req_i && req_d) state <= last_d ? GNT_I : GNT_D;
               else if (req_i)     state <= GNT_I;
               else if (req_d)     state <= GNT_D;
            end
            GNT_I, GNT_D: begin
               if (!own_cyc) begin
                  // Owner released: hand straight over to the other master if it waits.
                  last_d <= gnt_d;
                  cnt    <= '0;
                  if (gnt_d) state <= req_i ? GNT_I : IDLE;
                  else       state <= req_d ? GNT_D : IDLE;
               end else if (hung) begin
                  last_d    <= gnt_d;
                  cnt       <= '0;
                  timeout_q <= 1'b1;
                  state     <= ABORT;
               end else if (resp) begin
                  cnt <= '0;
               end else if (wbm_stb_o) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ABORT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: master responses are queued when the slave answers
// and compared at the falling edge; bus-side values are checked inline.
module tb_wb_bus_arbiter;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        iwbs_cyc_i, iwbs_stb_i;
   logic [31:0] iwbs_addr_i, iwbs_dat_o;
   logic        iwbs_ack_o, iwbs_err_o;
   logic        dwbs_cyc_i, dwbs_stb_i, dwbs_we_i;
   logic [3:0]  dwbs_sel_i;
   logic [31:0] dwbs_addr_i, dwbs_dat_i, dwbs_dat_o;
   logic        dwbs_ack_o, dwbs_err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i, timeout_o;

   always #5 clk = ~clk;

   wb_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i), .iwbs_addr_i(iwbs_addr_i),
      .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
      .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
      .dwbs_sel_i(dwbs_sel_i), .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i),
      .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .timeout_o(timeout_o)
   );

   int          checks = 0;
   int          errors = 0;
   logic [95:0] exp_q[$];

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] bus(input logic cyc, input logic stb, input logic we,
                                       input logic [3:0] sel, input logic [31:0] addr,
                                       input logic [31:0] dat);
      return {25'd0, cyc, stb, we, sel, addr, dat};
   endfunction

   function automatic logic [95:0] bus_now();
      return bus(wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o);
   endfunction

   function automatic logic [95:0] rsp(input logic ia, input logic ie, input logic da,
                                       input logic de, input logic to, input logic [31:0] dat);
      return {27'd0, ia, ie, da, de, to, dat, dat};
   endfunction

   function automatic logic [95:0] rsp_now();
      logic [4:0] f;
      f = {iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o, timeout_o};
      return (f == 5'd0) ? 96'd0 : {27'd0, f, iwbs_dat_o, dwbs_dat_o};
   endfunction

   // Every falling edge: a queued response must appear now, and nothing may appear unannounced.
   always @(negedge clk) begin
      if (exp_q.size() != 0) check("sb_resp", rsp_now(), exp_q.pop_front());
      else if (rsp_now() != 96'd0) check("sb_unexp", rsp_now(), 96'd0);
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout got no finish expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic i_req(input logic [31:0] addr);
      iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = addr;
   endtask

   task automatic d_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] dat);
      dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_we_i = we;
      dwbs_sel_i = sel; dwbs_addr_i = addr; dwbs_dat_i = dat;
   endtask

   task automatic i_drop();
      iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
   endtask

   task automatic d_drop();
      dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
   endtask

   task automatic slave(input logic ack, input logic err, input logic [31:0] dat);
      wbm_ack_i = ack; wbm_err_i = err; wbm_dat_i = dat;
   endtask

   initial begin
      rst_i = 1'b0;
      iwbs_cyc_i = 0; iwbs_stb_i = 0; iwbs_addr_i = '0;
      dwbs_cyc_i = 0; dwbs_stb_i = 0; dwbs_we_i = 0; dwbs_sel_i = '0;
      dwbs_addr_i = '0; dwbs_dat_i = '0;
      slave(1'b0, 1'b0, 32'h1234_5678);

      // Reset state
      repeat (2) @(posedge clk);
      smp();
      check("rst_bus", bus_now(), 96'd0);
      check("rst_resp", 96'({timeout_o, iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o}), 96'd0);
      check("rst_dat", 96'({iwbs_dat_o, dwbs_dat_o}), 96'({32'h1234_5678, 32'h1234_5678}));
      tick(); rst_i = 1'b1;
      tick(); slave(1'b1, 1'b0, 32'hCAFE_0000);
      smp(); check("idle_ack", 96'({iwbs_ack_o, dwbs_ack_o}), 96'd0);
      tick(); slave(1'b0, 1'b0, 32'd0);

      // Contention right after reset: D first, then I, then D again
      tick(); i_req(32'h200); d_req(1'b0, 4'hF, 32'h300, 32'd0);
      smp(); check("arb_wait", bus_now(), 96'd0);
      tick(); smp(); check("arb_first_d", bus_now(), bus(1, 1, 0, 4'hF, 32'h300, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'hA5A5_0001); exp_q.push_back(rsp(0, 0, 1, 0, 0, 32'hA5A5_0001));
      tick(); slave(1'b0, 1'b0, 32'd0); d_drop();
      smp(); check("d_release", 96'(wbm_cyc_o), 96'd0);
      tick(); smp(); check("handover_i", bus_now(), bus(1, 1, 0, 4'hF, 32'h200, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h11); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h11));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      tick(); i_req(32'h204); d_req(1'b0, 4'hF, 32'h304, 32'd0);
      tick(); smp(); check("arb2_d", bus_now(), bus(1, 1, 0, 4'hF, 32'h304, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h22); exp_q.push_back(rsp(0, 0, 1, 0, 0, 32'h22));
      tick(); slave(1'b0, 1'b0, 32'd0); d_drop();
      tick(); smp(); check("arb2_i", bus_now(), bus(1, 1, 0, 4'hF, 32'h204, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h33); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h33));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      tick();

      // Single instruction read
      i_req(32'h8000_0000);
      smp(); check("t1_stb_pre", 96'(wbm_stb_o), 96'd0);
      tick(); smp(); check("t1_bus", bus_now(), bus(1, 1, 0, 4'hF, 32'h8000_0000, 32'd0));
      tick();
      tick(); slave(1'b1, 1'b0, 32'h13); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h13));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      tick();

      // Data write while I waits, with a back-to-back strobe inside one cyc
      i_req(32'h400); d_req(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
      tick(); smp(); check("t3_bus", bus_now(), bus(1, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF));
      tick(); slave(1'b1, 1'b0, 32'd0); exp_q.push_back(rsp(0, 0, 1, 0, 0, 32'd0));
      tick(); slave(1'b0, 1'b0, 32'd0); dwbs_stb_i = 1'b0;
      smp(); check("t3_hold", bus_now(), bus(1, 0, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF));
      tick(); dwbs_stb_i = 1'b1; dwbs_addr_i = 32'h104; dwbs_dat_i = 32'h0BAD_F00D;
      slave(1'b1, 1'b0, 32'd0); exp_q.push_back(rsp(0, 0, 1, 0, 0, 32'd0));
      smp(); check("t3_b2b", bus_now(), bus(1, 1, 1, 4'b0011, 32'h104, 32'h0BAD_F00D));
      tick(); slave(1'b0, 1'b0, 32'd0); d_drop();
      tick(); smp(); check("t3_handover", bus_now(), bus(1, 1, 0, 4'hF, 32'h400, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h44); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h44));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      tick();

      // Watchdog: TO strobe cycles, one ABORT cycle, IDLE, then re-arbitration
      i_req(32'h500);
      tick();
      for (int k = 0; k < int'(TO); k++) begin
         smp(); check("to_stb", 96'(wbm_stb_o), 96'd1);
         tick();
      end
      exp_q.push_back(rsp(0, 1, 0, 0, 1, 32'd0));
      smp(); check("to_abort_bus", 96'({wbm_cyc_o, wbm_stb_o}), 96'd0);
      tick(); smp(); check("to_idle", bus_now(), 96'd0);
      tick(); smp(); check("to_rearb", 96'(wbm_stb_o), 96'd1);
      tick(); i_drop();
      tick();

      // Ack in the final counting cycle wins over the watchdog
      i_req(32'h600);
      tick(); tick(); tick();
      tick(); slave(1'b1, 1'b0, 32'h77); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h77));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      smp(); check("late_ack", 96'({timeout_o, wbm_cyc_o}), 96'd0);
      tick();

      // Slave error on a data read
      d_req(1'b0, 4'hF, 32'h700, 32'd0);
      tick(); slave(1'b0, 1'b1, 32'hEEEE_0000); exp_q.push_back(rsp(0, 0, 0, 1, 0, 32'hEEEE_0000));
      tick(); slave(1'b0, 1'b0, 32'd0); d_drop();
      smp(); check("err_release", 96'(wbm_cyc_o), 96'd0);
      tick(); smp(); check("err_idle", bus_now(), 96'd0);

      // Asynchronous reset mid-transfer, then contention grants D
      tick(); d_req(1'b0, 4'hF, 32'h800, 32'd0);
      tick(); i_req(32'h900);
      smp(); check("rst_pre", 96'({wbm_cyc_o, wbm_stb_o}), 96'd3);
      @(posedge clk); #3;
      rst_i = 1'b0; slave(1'b1, 1'b0, 32'h5555);
      #1; check("rst_async", 96'({wbm_cyc_o, wbm_stb_o, dwbs_ack_o}), 96'd0);
      @(posedge clk); #2;
      rst_i = 1'b1; slave(1'b0, 1'b0, 32'd0);
      smp(); check("rst_rel_idle", bus_now(), 96'd0);
      tick(); smp(); check("rst_arb_d", bus_now(), bus(1, 1, 0, 4'hF, 32'h800, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h1); exp_q.push_back(rsp(0, 0, 1, 0, 0, 32'h1));
      tick(); slave(1'b0, 1'b0, 32'd0); d_drop();
      tick(); smp(); check("rst_handover_i", bus_now(), bus(1, 1, 0, 4'hF, 32'h900, 32'd0));
      tick(); slave(1'b1, 1'b0, 32'h2); exp_q.push_back(rsp(1, 0, 0, 0, 0, 32'h2));
      tick(); slave(1'b0, 1'b0, 32'd0); i_drop();
      tick(); tick();

      check("sb_left", 96'(exp_q.size()), 96'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
